formant_dp_seg: RTL and testbench
=================================

Name: formant_dp_seg

Overview:
- Parametrised dynamic-programming segmentation core for the formant estimator.
- Consumes a stream of segment costs c(j,i) and computes the recursions F[k][i] (best cost of covering bins 0..i with k segments) and B[k][i] (argmin start bin).
- After the last row it traces back and streams out the K segment start bins.
- Successor to the fixed-size F/B stage:
  - bin count and formant count are selectable at run time, up to compile-time maxima;
  - input and output use valid/ready handshakes;
  - the block performs its own traceback.

Parameters:
- COST_W, 32, cost width; unsigned, saturating.
- MAX_BINS, 160, maximum bins per frame (N).
- MAX_K, 5, maximum number of segments (K).
- BIN_W, $clog2(MAX_BINS), bin index width.
- K_W, $clog2(MAX_K+1), segment count width.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset.
- start  in  1  pulse; latches cfg_bins and cfg_k; honoured only in IDLE.
- cfg_bins  in  BIN_W+1  N; legal range 2..MAX_BINS.
- cfg_k  in  K_W  K; legal range 1..MAX_K, K<=N.
- e_valid  in  1  cost beat valid.
- e_ready  out  1  cost beat accepted when e_valid&e_ready.
- e_cost  in  COST_W  c(j,i) = cost of one segment spanning bins j..i inclusive.
- e_last  in  1  marks j==i, the final beat of row i.
- b_valid  out  1  boundary output valid.
- b_ready  in  1  boundary output ready.
- b_bin  out  BIN_W  start bin of the segment.
- b_idx  out  K_W  segment number, 1..K.
- b_last  out  1  high on the segment-1 beat.
- busy  out  1  high in any state except IDLE.
- proto_err  out  1  sticky; cleared by start.

Behaviour:
- Reset is asynchronous and active-high on rst_in, with single clock clk_in.
- Reset values: state=IDLE; e_ready, b_valid, b_last, busy, proto_err = 0; b_bin=0; b_idx=0; row/column counters = 0.
- Stream order: rows i=0..N-1. Within row i, beats j=0..i in ascending j order. Total N(N+1)/2 beats.
- ACCUM:
  - e_ready=1. Every accepted beat updates, for all k in parallel: cand_k = F[k-1][j-1] + c(j,i).
  - Base case k=1: cand_1 = c(0,i) for j=0; j>0 is infinite.
  - Candidates with j<k-1 are infinite. Infinite = all-ones.
  - Addition saturates at all-ones.
  - If cand_k < run_min_k: run_min_k <= cand_k and run_arg_k <= j. Ties keep the lower j.
  - run_min resets to all-ones at each row start.
  - F arrays are read asynchronously at address j-1, so the block sustains one beat per cycle.
- COMMIT:
  - Entered the cycle after an accepted e_last. Lasts one cycle, with e_ready=0.
  - Writes F[k][i] <= run_min_k and B[k][i] <= run_arg_k for k=1..K.
  - If i<N-1: i++, j=0, go to ACCUM. Otherwise go to TRACE with end=N-1, k=K.
- TRACE:
  - b_valid=1, b_bin=B[k][end], b_idx=k, b_last=(k==1).
  - On b_valid&b_ready: end <= B[k][end]-1, k--. After the k==1 handshake, go to IDLE.
  - Output holds stable while b_ready=0.
  - b_idx descends K..1; the segment-1 bin is always 0.
- IDLE:
  - start with legal cfg goes to ACCUM with i=0, j=0.
  - start with illegal cfg (N<2, K=0, K>MAX_K, K>N) sets proto_err and the block stays in IDLE.
  - start outside IDLE is ignored.
- Protocol errors:
  - e_last accepted with j!=i, or j==i accepted without e_last, sets proto_err.
  - Recovery: the block aborts to IDLE next cycle, without a traceback.
- Reset mid-frame returns to IDLE immediately. F/B contents are don't-care; they are rewritten before being read.

Optional Feature:
- FORMANT_DP_SEG_COST_OUT_EN defined:
  - adds output port total_cost [COST_W], which equals F[K][N-1];
  - valid alongside every TRACE beat;
  - reset value 0.
- Undefined: the port is absent and no extra logic is built.

Decomposition:
- Package formant_pkg holds:
  - state typedef {IDLE, ACCUM, COMMIT, TRACE};
  - COST_INF constant;
  - sat_add function;
  - default MAX_BINS/MAX_K constants shared with the T/Emin stages.
- Sub-module dp_min_cell (one per k, generated): saturating add, compare, running min/arg registers, row-start clear.

Test Plan:
- N=4, K=2, c(j,i)=(i-j)^2 for all beats → boundaries b_idx=2 bin 2, then b_idx=1 bin 0 with b_last. Optional total_cost=2.
- N=3, K=1, c(0,i)=5, all else 1 → single beat: b_bin=0, b_idx=1, b_last=1. Optional total_cost=5.
- Ties: N=3, K=2, all costs 0 → segment-2 bin=1 (lowest legal j); no proto_err.
- Saturation: N=3, K=2, all costs 0xFFFF_FFF0 → no wraparound; total_cost=0xFFFF_FFFF; boundaries still valid.
- Backpressure: hold b_ready=0 for 10 cycles in TRACE → b_bin/b_idx stable; sequence unchanged when b_ready is released. Random e_valid gaps → identical result.
- Errors:
  - e_last asserted on beat j=0 of row 1 → proto_err=1, return to IDLE, b_valid never asserted.
  - start with cfg_k=0 → proto_err=1, busy stays 0.
  - Async reset mid-ACCUM → all outputs 0 within the same cycle.

Source files
------------

// File: rtl/formant_pkg.sv
// formant_pkg
//   Shared types and helpers for the formant estimator stages.
//   - state_t   : segmentation FSM states
//   - COST_INF  : "infinite" cost (all-ones); also the saturation ceiling
//   - sat_add   : unsigned saturating add at FMT_COST_W bits
//   - FMT_*     : default frame geometry shared with the T/Emin stages
package formant_pkg;

  localparam int FMT_COST_W   = 32;
  localparam int FMT_MAX_BINS = 160;
  localparam int FMT_MAX_K    = 5;

  localparam logic [FMT_COST_W-1:0] COST_INF = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    COMMIT = 2'd2,
    TRACE  = 2'd3
  } state_t;

  // Adds in one extra bit and clamps on carry-out, so an infinite operand
  // stays infinite and large finite sums never wrap.
  function automatic logic [FMT_COST_W-1:0] sat_add(input logic [FMT_COST_W-1:0] a,
                                                    input logic [FMT_COST_W-1:0] b);
    logic [FMT_COST_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[FMT_COST_W] ? COST_INF : s[FMT_COST_W-1:0];
  endfunction

endpackage

// File: rtl/dp_min_cell.sv
// dp_min_cell
//   One row-minimum tracker for a single segment count k. Each enabled beat
//   forms cand = prev_cost + cost (saturating, or infinite when cand_inf)
//   and keeps the smallest candidate together with the start bin j.
// Ports:
//   clk_in, rst_in  clock, async active-high reset
//   clr             return run_min to infinite and run_arg to 0 (row start)
//   en              accepted cost beat
//   cand_inf        this candidate is infeasible for this k
//   first           j is the lowest legal start bin for this k
//   prev_cost       F[k-1][j-1] (0 for the k=1 base case)
//   cost            c(j,i)
//   j               start bin of the current beat
//   run_min/run_arg running minimum cost and its start bin
module dp_min_cell
  import formant_pkg::*;
#(
  parameter int COST_W = FMT_COST_W,
  parameter int BIN_W  = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clr,
  input  logic              en,
  input  logic              cand_inf,
  input  logic              first,
  input  logic [COST_W-1:0] prev_cost,
  input  logic [COST_W-1:0] cost,
  input  logic [BIN_W-1:0]  j,
  output logic [COST_W-1:0] run_min,
  output logic [BIN_W-1:0]  run_arg
);

  logic [COST_W-1:0] cand;

  always_comb begin
    cand = cand_inf ? COST_INF : sat_add(prev_cost, cost);
  end

  // The first legal j is always taken so run_arg points at a reachable bin
  // even when every candidate saturates to infinite; later ties are
  // rejected by the strict compare, which keeps the lower j.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      run_min <= COST_INF;
      run_arg <= '0;
    end else if (clr) begin
      run_min <= COST_INF;
      run_arg <= '0;
    end else if (en && (first || (cand < run_min))) begin
      run_min <= cand;
      run_arg <= j;
    end
  end

endmodule

// File: rtl/formant_dp_seg.sv
// formant_dp_seg
//   Dynamic-programming segmentation core. Consumes segment costs c(j,i)
//   row by row, builds F[k][i] / B[k][i] for k=1..K, then traces back and
//   streams the K segment start bins, segment K first.
// Ports:
//   clk_in, rst_in            clock, async active-high reset
//   start, cfg_bins, cfg_k    frame start (IDLE only) with N and K
//   e_valid/e_ready/e_cost/e_last   cost input stream
//   b_valid/b_ready/b_bin/b_idx/b_last  boundary output stream
//   busy                      not IDLE
//   proto_err                 sticky config/stream error, cleared by start
//   dbg_state                 FSM state for observation
//   total_cost                F[K][N-1], only with FORMANT_DP_SEG_COST_OUT_EN
// Handshakes: a beat transfers on the rising clk_in edge where valid and
// ready are both high; a valid source holds its payload until that edge.
module formant_dp_seg
  import formant_pkg::*;
#(
  parameter int COST_W   = FMT_COST_W,
  parameter int MAX_BINS = FMT_MAX_BINS,
  parameter int MAX_K    = FMT_MAX_K,
  parameter int BIN_W    = $clog2(MAX_BINS),
  parameter int K_W      = $clog2(MAX_K + 1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start,
  input  logic [BIN_W:0]    cfg_bins,
  input  logic [K_W-1:0]    cfg_k,
  input  logic              e_valid,
  output logic              e_ready,
  input  logic [COST_W-1:0] e_cost,
  input  logic              e_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [BIN_W-1:0]  b_bin,
  output logic [K_W-1:0]    b_idx,
  output logic              b_last,
  output logic              busy,
  output logic              proto_err,
`ifdef FORMANT_DP_SEG_COST_OUT_EN
  output logic [COST_W-1:0] total_cost,
`endif
  output state_t            dbg_state
);

  state_t           state;
  logic [BIN_W:0]   n_cfg;
  logic [K_W-1:0]   k_cfg;
  logic [BIN_W-1:0] row;
  logic [BIN_W-1:0] col;
  logic [BIN_W-1:0] jm1;
  logic             cfg_ok;
  logic [BIN_W:0]   k_ext;
  logic             cell_clr;
  logic             cell_en;

  logic [COST_W-1:0] f_mem [1:MAX_K][0:MAX_BINS-1];
  logic [BIN_W-1:0]  b_mem [1:MAX_K][0:MAX_BINS-1];

  logic [COST_W-1:0] run_min_a [1:MAX_K];
  logic [BIN_W-1:0]  run_arg_a [1:MAX_K];

  assign dbg_state = state;
  assign jm1       = col - 1'b1;
  assign k_ext     = {{(BIN_W + 1 - K_W){1'b0}}, cfg_k};
  assign cfg_ok    = (cfg_bins >= (BIN_W+1)'(2)) && (cfg_bins <= (BIN_W+1)'(MAX_BINS)) &&
                     (cfg_k != '0) && (cfg_k <= K_W'(MAX_K)) && (k_ext <= cfg_bins);

  // Running minima only live inside ACCUM; every other state holds them at
  // the row-start value, so COMMIT's clear also prepares the next row.
  assign cell_clr = (state != ACCUM);
  assign cell_en  = e_valid && e_ready;

  for (genvar g = 1; g <= MAX_K; g++) begin : g_cell
    localparam logic [BIN_W-1:0] KM1 = BIN_W'(g - 1);
    logic [COST_W-1:0] prev_cost;
    logic              cand_inf;

    if (g == 1) begin : g_base
      assign prev_cost = '0;
      assign cand_inf  = (col != '0);
    end else begin : g_rec
      // j=0 reads garbage at address -1, but j<k-1 always masks it.
      assign prev_cost = f_mem[g-1][jm1];
      assign cand_inf  = (col < KM1);
    end

    dp_min_cell #(
      .COST_W (COST_W),
      .BIN_W  (BIN_W)
    ) u_cell (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .clr       (cell_clr),
      .en        (cell_en),
      .cand_inf  (cand_inf),
      .first     (col == KM1),
      .prev_cost (prev_cost),
      .cost      (e_cost),
      .j         (col),
      .run_min   (run_min_a[g]),
      .run_arg   (run_arg_a[g])
    );
  end

  always_ff @(posedge clk_in) begin
    if (state == COMMIT) begin
      for (int k = 1; k <= MAX_K; k++) begin
        f_mem[k][row] <= run_min_a[k];
        b_mem[k][row] <= run_arg_a[k];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      n_cfg     <= '0;
      k_cfg     <= '0;
      row       <= '0;
      col       <= '0;
      e_ready   <= 1'b0;
      b_valid   <= 1'b0;
      b_bin     <= '0;
      b_idx     <= '0;
      b_last    <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
`ifdef FORMANT_DP_SEG_COST_OUT_EN
      total_cost <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            proto_err <= !cfg_ok;
            if (cfg_ok) begin
              n_cfg   <= cfg_bins;
              k_cfg   <= cfg_k;
              row     <= '0;
              col     <= '0;
              state   <= ACCUM;
              e_ready <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (e_valid) begin
            if (e_last != (col == row)) begin
              proto_err <= 1'b1;
              state     <= IDLE;
              e_ready   <= 1'b0;
              busy      <= 1'b0;
            end else if (e_last) begin
              state   <= COMMIT;
              e_ready <= 1'b0;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        COMMIT: begin
          if ({1'b0, row} == n_cfg - 1'b1) begin
            // B[K][N-1] is written this same edge, so take it from the cell.
            state   <= TRACE;
            b_valid <= 1'b1;
            b_idx   <= k_cfg;
            b_bin   <= run_arg_a[k_cfg];
            b_last  <= (k_cfg == K_W'(1));
`ifdef FORMANT_DP_SEG_COST_OUT_EN
            total_cost <= run_min_a[k_cfg];
`endif
          end else begin
            row     <= row + 1'b1;
            col     <= '0;
            state   <= ACCUM;
            e_ready <= 1'b1;
          end
        end
        TRACE: begin
          if (b_ready) begin
            if (b_last) begin
              state   <= IDLE;
              b_valid <= 1'b0;
              b_last  <= 1'b0;
              b_bin   <= '0;
              b_idx   <= '0;
              busy    <= 1'b0;
            end else begin
              // The previous segment ends one bin before this one starts.
              b_idx  <= b_idx - 1'b1;
              b_bin  <= b_mem[b_idx - 1'b1][b_bin - 1'b1];
              b_last <= (b_idx == K_W'(2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_formant_dp_seg.sv
// tb_formant_dp_seg
//   Directed bench for formant_dp_seg with hand-computed boundaries.
//   Build with FORMANT_DP_SEG_COST_OUT_EN defined to also cover total_cost.
module tb_formant_dp_seg;
  import formant_pkg::*;

  localparam int COST_W = 32;
  localparam int BIN_W  = 8;
  localparam int K_W    = 3;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              start = 1'b0;
  logic [BIN_W:0]    cfg_bins = '0;
  logic [K_W-1:0]    cfg_k = '0;
  logic              e_valid = 1'b0;
  logic              e_ready;
  logic [COST_W-1:0] e_cost = '0;
  logic              e_last = 1'b0;
  logic              b_valid;
  logic              b_ready = 1'b0;
  logic [BIN_W-1:0]  b_bin;
  logic [K_W-1:0]    b_idx;
  logic              b_last;
  logic              busy;
  logic              proto_err;
  state_t            dbg_state;
`ifdef FORMANT_DP_SEG_COST_OUT_EN
  logic [COST_W-1:0] total_cost;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [BIN_W-1:0] exp_q[$];

  formant_dp_seg u_dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start     (start),
    .cfg_bins  (cfg_bins),
    .cfg_k     (cfg_k),
    .e_valid   (e_valid),
    .e_ready   (e_ready),
    .e_cost    (e_cost),
    .e_last    (e_last),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_bin     (b_bin),
    .b_idx     (b_idx),
    .b_last    (b_last),
    .busy      (busy),
    .proto_err (proto_err),
`ifdef FORMANT_DP_SEG_COST_OUT_EN
    .total_cost(total_cost),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [COST_W-1:0] cost_of(input int mode, input int i, input int j);
    case (mode)
      0:       return COST_W'((i - j) * (i - j));
      1:       return (j == 0) ? 32'd5 : 32'd1;
      2:       return 32'd0;
      default: return 32'hFFFF_FFF0;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic pulse_start(input int n, input int k);
    cfg_bins = (BIN_W+1)'(n);
    cfg_k    = K_W'(k);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic send_beat(input logic [COST_W-1:0] c, input logic last);
    int cnt;
    cnt = 0;
    while (!e_ready && cnt < 100) begin
      tick();
      cnt++;
    end
    if (cnt >= 100) check("e_ready_timeout", 0, 1);
    e_valid = 1'b1;
    e_cost  = c;
    e_last  = last;
    tick();
    e_valid = 1'b0;
    e_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int mode, input bit gaps);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j <= i; j++) begin
        if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
        send_beat(cost_of(mode, i, j), j == i);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic collect_trace(input int k, input bit hold, input logic [COST_W-1:0] exp_total);
    int cnt;
    logic [BIN_W-1:0] eb;
    for (int s = k; s >= 1; s--) begin
      cnt = 0;
      while (!b_valid && cnt < 200) begin
        tick();
        cnt++;
      end
      check("b_valid", b_valid, 1);
      if (exp_q.size() == 0) begin
        check("exp_q_underrun", 0, 1);
        eb = '0;
      end else begin
        eb = exp_q[0];
      end
      if (hold && s == k) begin
        repeat (10) begin
          tick();
          check("hold_bin", b_bin, eb);
          check("hold_idx", b_idx, s);
          check("hold_valid", b_valid, 1);
        end
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      check("b_bin", b_bin, eb);
      check("b_idx", b_idx, s);
      check("b_last", b_last, s == 1);
`ifdef FORMANT_DP_SEG_COST_OUT_EN
      check("total_cost", total_cost, exp_total);
`endif
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
    end
    check("trace_busy_done", busy, 0);
    check("trace_valid_done", b_valid, 0);
    check("exp_q_empty", exp_q.size(), 0);
    check("frame_no_err", proto_err, 0);
  endtask

  task automatic run_frame(input int n, input int k, input int mode, input bit gaps,
                           input bit hold, input logic [COST_W-1:0] exp_total);
    pulse_start(n, k);
    check("start_busy", busy, 1);
    send_frame(n, mode, gaps);
    collect_trace(k, hold, exp_total);
  endtask

  // ---------------- sequence ----------------
  initial begin
    int seen;

    repeat (2) tick();
    check("rst_e_ready", e_ready, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_b_last", b_last, 0);
    check("rst_busy", busy, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_b_bin", b_bin, 0);
    check("rst_b_idx", b_idx, 0);
    check("rst_state", dbg_state, IDLE);
`ifdef FORMANT_DP_SEG_COST_OUT_EN
    check("rst_total", total_cost, 0);
`endif
    rst_in = 1'b0;
    tick();

    // N=4 K=2, c=(i-j)^2
    exp_q.push_back(8'd2); exp_q.push_back(8'd0);
    run_frame(4, 2, 0, 1'b0, 1'b0, 32'd2);

    // e_last on row 1 beat j=0
    pulse_start(3, 2);
    send_beat(32'd0, 1'b1);
    send_beat(32'd0, 1'b1);
    check("err_last_flag", proto_err, 1);
    check("err_last_state", dbg_state, IDLE);
    check("err_last_e_ready", e_ready, 0);
    seen = 0;
    repeat (10) begin
      if (b_valid) seen++;
      tick();
    end
    check("err_last_no_bvalid", seen, 0);
    check("err_last_busy", busy, 0);

    // N=3 K=1, c(0,i)=5 else 1; start also clears proto_err
    exp_q.push_back(8'd0);
    run_frame(3, 1, 1, 1'b0, 1'b0, 32'd5);

    // illegal K=0
    pulse_start(3, 0);
    check("cfg_k0_err", proto_err, 1);
    check("cfg_k0_busy", busy, 0);
    tick();
    check("cfg_k0_busy_hold", busy, 0);
    check("cfg_k0_e_ready", e_ready, 0);

    // ties: all zero costs
    exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    run_frame(3, 2, 2, 1'b0, 1'b0, 32'd0);

    // saturation
    exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    run_frame(3, 2, 3, 1'b0, 1'b0, 32'hFFFF_FFFF);

    // input gaps and output backpressure on the first case
    exp_q.push_back(8'd2); exp_q.push_back(8'd0);
    run_frame(4, 2, 0, 1'b1, 1'b1, 32'd2);

    // N=5 K=3, c=(i-j)^2
    exp_q.push_back(8'd3); exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    run_frame(5, 3, 0, 1'b1, 1'b0, 32'd2);

    // async reset mid-ACCUM
    pulse_start(4, 2);
    send_beat(32'd0, 1'b1);
    send_beat(32'd1, 1'b0);
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_e_ready", e_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_b_valid", b_valid, 0);
    check("arst_proto_err", proto_err, 0);
    check("arst_state", dbg_state, IDLE);
    tick();
    rst_in = 1'b0;
    tick();

    // clean frame after reset
    exp_q.push_back(8'd2); exp_q.push_back(8'd0);
    run_frame(4, 2, 0, 1'b0, 1'b0, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
